// File: rtl/exe_mem_stage_buffer.sv
// EXE->MEM pipeline register with valid/ready handshake, optional one-entry skid,
// synchronous flush and a saturating output-stall counter.
module exe_mem_stage_buffer #(
    parameter int WORD_W      = 32,
    parameter int DEST_W      = 4,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   WB_en_in,
    input  logic                   MEM_R_EN_in,
    input  logic                   MEM_W_EN_in,
    input  logic [WORD_W-1:0]      ALU_result_in,
    input  logic [WORD_W-1:0]      ST_val_in,
    input  logic [WORD_W-1:0]      PC_in,
    input  logic [WORD_W-1:0]      Instruction_in,
    input  logic [DEST_W-1:0]      Dest_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   WB_en,
    output logic                   MEM_R_EN,
    output logic                   MEM_W_EN,
    output logic [WORD_W-1:0]      ALU_result,
    output logic [WORD_W-1:0]      ST_val,
    output logic [WORD_W-1:0]      PC,
    output logic [WORD_W-1:0]      Instruction,
    output logic [DEST_W-1:0]      Dest,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int BW = 3 + 4 * WORD_W + DEST_W;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    // Handshake: a bundle moves when valid and ready are both high at a rising edge;
    // valid never depends on ready, and flush overrides any transfer on the input side.
    logic [BW-1:0]          in_bundle;
    logic [BW-1:0]          main_q, main_d;
    logic [BW-1:0]          skid_q, skid_d;
    logic                   main_valid_q, main_valid_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   accept;
    logic                   pop;
    logic                   wb_s, mem_r_s, mem_w_s;

    assign in_bundle = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in,
                        PC_in, Instruction_in, Dest_in};

    // With the skid, ready comes straight from a flop so it never depends on out_ready.
    assign in_ready = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_q || pop) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = accept;
                    if (accept) begin
                        skid_d = in_bundle;
                    end
                end else if (accept) begin
                    main_d       = in_bundle;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = in_bundle;
                skid_valid_d = 1'b1;
            end
        end else begin
            if (accept) begin
                main_d       = in_bundle;
                main_valid_d = 1'b1;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Data fields are left ungated; only the enables are qualified by valid.
    assign {wb_s, mem_r_s, mem_w_s, ALU_result, ST_val, PC, Instruction, Dest} = main_q;
    assign out_valid = main_valid_q;
    assign WB_en     = wb_s & main_valid_q;
    assign MEM_R_EN  = mem_r_s & main_valid_q;
    assign MEM_W_EN  = mem_w_s & main_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_mem_stage_buffer.sv
// Bench for exe_mem_stage_buffer: three instances (skid, no skid, 4-bit stall counter)
// share one stimulus stream; directed tables plus a randomized queue-model phase.
module tb_exe_mem_stage_buffer;

    localparam int W  = 32;
    localparam int DW = 4;
    localparam int BW = 3 + 4 * W + DW;

    logic          clk, rst, flush, in_valid, out_ready;
    logic          wb_in, mr_in, mw_in;
    logic [W-1:0]  alu_in, st_in, pc_in, ins_in;
    logic [DW-1:0] dest_in;

    logic          ir_1, ov_1, wb_1, mr_1, mw_1;
    logic [W-1:0]  alu_1, st_1, pc_1, ins_1;
    logic [DW-1:0] dest_1;
    logic [15:0]   stall_1;

    logic          ir_0, ov_0, wb_0, mr_0, mw_0;
    logic [W-1:0]  alu_0, st_0, pc_0, ins_0;
    logic [DW-1:0] dest_0;
    logic [15:0]   stall_0;

    logic          ir_s, ov_s, wb_s, mr_s, mw_s;
    logic [W-1:0]  alu_s, st_s, pc_s, ins_s;
    logic [DW-1:0] dest_s;
    logic [3:0]    stall_s;

    logic [BW-1:0] ob1, ob0, obs, in_b;
    assign ob1  = {wb_1, mr_1, mw_1, alu_1, st_1, pc_1, ins_1, dest_1};
    assign ob0  = {wb_0, mr_0, mw_0, alu_0, st_0, pc_0, ins_0, dest_0};
    assign obs  = {wb_s, mr_s, mw_s, alu_s, st_s, pc_s, ins_s, dest_s};
    assign in_b = {wb_in, mr_in, mw_in, alu_in, st_in, pc_in, ins_in, dest_in};

    exe_mem_stage_buffer #(.WORD_W(W), .DEST_W(DW), .SKID(1), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_1),
        .WB_en_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(alu_in), .ST_val_in(st_in), .PC_in(pc_in), .Instruction_in(ins_in),
        .Dest_in(dest_in), .out_valid(ov_1), .out_ready(out_ready),
        .WB_en(wb_1), .MEM_R_EN(mr_1), .MEM_W_EN(mw_1), .ALU_result(alu_1), .ST_val(st_1),
        .PC(pc_1), .Instruction(ins_1), .Dest(dest_1), .stall_cnt(stall_1));

    exe_mem_stage_buffer #(.WORD_W(W), .DEST_W(DW), .SKID(0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_0),
        .WB_en_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(alu_in), .ST_val_in(st_in), .PC_in(pc_in), .Instruction_in(ins_in),
        .Dest_in(dest_in), .out_valid(ov_0), .out_ready(out_ready),
        .WB_en(wb_0), .MEM_R_EN(mr_0), .MEM_W_EN(mw_0), .ALU_result(alu_0), .ST_val(st_0),
        .PC(pc_0), .Instruction(ins_0), .Dest(dest_0), .stall_cnt(stall_0));

    exe_mem_stage_buffer #(.WORD_W(W), .DEST_W(DW), .SKID(1), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
        .WB_en_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(alu_in), .ST_val_in(st_in), .PC_in(pc_in), .Instruction_in(ins_in),
        .Dest_in(dest_in), .out_valid(ov_s), .out_ready(out_ready),
        .WB_en(wb_s), .MEM_R_EN(mr_s), .MEM_W_EN(mw_s), .ALU_result(alu_s), .ST_val(st_s),
        .PC(pc_s), .Instruction(ins_s), .Dest(dest_s), .stall_cnt(stall_s));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] pc, input logic ordy,
                         input logic fl, input logic mw);
        in_valid  = iv;
        pc_in     = pc;
        out_ready = ordy;
        flush     = fl;
        mw_in     = mw;
        wb_in     = 1'b0;
        mr_in     = 1'b0;
        alu_in    = pc ^ 32'hA5A5_0000;
        st_in     = ~pc;
        ins_in    = pc + 32'h13;
        dest_in   = pc[5:2];
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] pc;
        logic         mw;
        logic         ordy;
        logic         fl;
        logic         exp_ir;
        logic         exp_ov;
        logic [W-1:0] exp_pc;
        logic         exp_mw;
        int           exp_stall;
    } vec_t;

    vec_t tbl[12];

    logic [BW-1:0] exp_q1[$];
    logic [BW-1:0] exp_q0[$];
    int st1, st0, sts;
    logic m1_rdy, m0_rdy;

    initial begin
        // back-pressure then flush on the skid instance
        tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 0};
        tbl[1]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1};
        tbl[2]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 2};
        tbl[3]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 3};
        tbl[4]  = '{1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 3};
        tbl[5]  = '{1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 3};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 3};
        tbl[7]  = '{1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 3};
        tbl[8]  = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 4};
        tbl[9]  = '{1'b1, 32'h28, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 5};
        tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5};
        tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ov_s1", ov_1, 1'b0);
        check("reset_ir_s1", ir_1, 1'b1);
        check("reset_ir_s0", ir_0, 1'b1);
        check("reset_en_s1", {wb_1, mr_1, mw_1}, 3'b0);
        check("reset_stall_s1", stall_1, 16'd0);
        check("reset_ov_s0", ov_0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].mw);
            #1;
            check($sformatf("tbl%0d_in_ready", i), ir_1, tbl[i].exp_ir);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out_valid", i), ov_1, tbl[i].exp_ov);
            check($sformatf("tbl%0d_mem_w_en", i), mw_1, tbl[i].exp_mw);
            check($sformatf("tbl%0d_stall", i), stall_1, tbl[i].exp_stall);
            if (tbl[i].exp_ov) check($sformatf("tbl%0d_pc", i), pc_1, tbl[i].exp_pc);
        end

        // streaming in both modes, one bundle per cycle
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
            #1;
            check("stream_ir_s1", ir_1, 1'b1);
            check("stream_ir_s0", ir_0, 1'b1);
            @(posedge clk);
            #1;
            check("stream_ov_s1", ov_1, 1'b1);
            check("stream_pc_s1", pc_1, 32'(i * 4));
            check("stream_ov_s0", ov_0, 1'b1);
            check("stream_pc_s0", pc_0, 32'(i * 4));
        end

        // combinational ready without skid
        apply_reset();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        #1 check("s0_ir_empty", ir_0, 1'b1);
        @(posedge clk);
        #1 drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        #1 check("s0_ir_full_stalled", ir_0, 1'b0);
        @(posedge clk);
        #1 check("s0_hold_pc", pc_0, 32'h40);
        out_ready = 1'b1;
        #1 check("s0_ir_full_popping", ir_0, 1'b1);
        @(posedge clk);
        #1;
        check("s0_next_ov", ov_0, 1'b1);
        check("s0_next_pc", pc_0, 32'h44);

        // asynchronous reset with main and skid full
        apply_reset();
        drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
        wb_in = 1'b1;
        mr_in = 1'b1;
        @(posedge clk);
        #1 pc_in = 32'h54;
        @(posedge clk);
        #1;
        check("pre_rst_ir_s1", ir_1, 1'b0);
        check("pre_rst_en_s1", {wb_1, mr_1, mw_1}, 3'b111);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_ov_s1", ov_1, 1'b0);
        check("midrst_en_s1", {wb_1, mr_1, mw_1}, 3'b0);
        check("midrst_ir_s1", ir_1, 1'b1);
        check("midrst_stall_s1", stall_1, 16'd0);
        check("midrst_ov_s0", ov_0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("postrst_ov_s1", ov_1, 1'b0);

        // stall counter saturation on the 4-bit instance
        apply_reset();
        drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 check($sformatf("sat_stall_%0d", k), stall_s, (k > 15) ? 15 : k);
        end
        check("nosat_stall_s1", stall_1, 16'd20);

        // randomized traffic against a FIFO-occupancy model
        apply_reset();
        st1 = 0;
        st0 = 0;
        sts = 0;
        exp_q1.delete();
        exp_q0.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            {wb_in, mr_in, mw_in} = 3'($urandom_range(0, 7));
            alu_in  = $urandom;
            st_in   = $urandom;
            pc_in   = $urandom;
            ins_in  = $urandom;
            dest_in = 4'($urandom_range(0, 15));
            #1;
            m1_rdy = (exp_q1.size() < 2);
            m0_rdy = (exp_q0.size() == 0) || out_ready;
            check("rnd_ir_s1", ir_1, m1_rdy);
            check("rnd_ir_sat", ir_s, m1_rdy);
            check("rnd_ir_s0", ir_0, m0_rdy);
            if (exp_q1.size() > 0 && !out_ready) begin
                st1++;
                if (sts < 15) sts++;
            end
            if (exp_q0.size() > 0 && !out_ready) st0++;
            if (flush) begin
                exp_q1.delete();
                exp_q0.delete();
            end else begin
                if (exp_q1.size() > 0 && out_ready) void'(exp_q1.pop_front());
                if (in_valid && m1_rdy) exp_q1.push_back(in_b);
                if (exp_q0.size() > 0 && out_ready) void'(exp_q0.pop_front());
                if (in_valid && m0_rdy) exp_q0.push_back(in_b);
            end
            @(posedge clk);
            #1;
            check("rnd_ov_s1", ov_1, exp_q1.size() > 0);
            check("rnd_ov_sat", ov_s, exp_q1.size() > 0);
            check("rnd_ov_s0", ov_0, exp_q0.size() > 0);
            if (exp_q1.size() > 0) begin
                check("rnd_bundle_s1", ob1, exp_q1[0]);
                check("rnd_bundle_sat", obs, exp_q1[0]);
            end else begin
                check("rnd_en_s1", {wb_1, mr_1, mw_1}, 3'b0);
            end
            if (exp_q0.size() > 0) check("rnd_bundle_s0", ob0, exp_q0[0]);
            else check("rnd_en_s0", {wb_0, mr_0, mw_0}, 3'b0);
            check("rnd_stall_s1", stall_1, st1);
            check("rnd_stall_s0", stall_0, st0);
            check("rnd_stall_sat", stall_s, sts);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
